// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot iteration controller.
//   state_t   : controller FSM encoding (IDLE, START, WAIT, DONE)
//   DEF_WIDTH : default fixed-point word width shared with the ALU
//   FRAC/ONE  : fractional bit count and the value 1.0 in 2.(WIDTH-2) format
package mandelbrot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int FRAC      = DEF_WIDTH - 2;
  localparam int ONE       = 1 << FRAC;

endpackage

// File: rtl/mandelbrot_iter_ctrl.sv
// Per-pixel iteration controller for the Mandelbrot single-step ALU.
// Accepts c = (cr, ci), starts z at 0 and steps the external ALU one
// iteration at a time until z escapes or max_iter iterations are done.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         pixel request handshake (ready only in IDLE)
//   in_cr, in_ci, max_iter    pixel and its iteration limit, sampled on accept
//   out_valid/out_ready       result handshake
//   out_iter, out_escaped     iteration count and escape flag
//   alu_start, alu_finished   one-cycle start pulse / ALU result valid
//   alu_cr/ci, alu_zr/zi      operands held stable from START through WAIT
//   alu_out_zr/zi             next z from the ALU
//   alu_size, alu_overflow    escape indications from the ALU
//
// state | meaning
// IDLE  | waiting for a pixel, in_ready=1
// START | alu_start high for this single cycle
// WAIT  | waiting for alu_finished (first cycle masked)
// DONE  | result presented until out_ready
module mandelbrot_iter_ctrl
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_cr,
  input  logic [WIDTH-1:0]  in_ci,
  input  logic [ITER_W-1:0] max_iter,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] out_iter,
  output logic              out_escaped,
  output logic              alu_start,
  input  logic              alu_finished,
  output logic [WIDTH-1:0]  alu_cr,
  output logic [WIDTH-1:0]  alu_ci,
  output logic [WIDTH-1:0]  alu_zr,
  output logic [WIDTH-1:0]  alu_zi,
  input  logic [WIDTH-1:0]  alu_out_zr,
  input  logic [WIDTH-1:0]  alu_out_zi,
  input  logic              alu_size,
  input  logic              alu_overflow
);

  state_t            state;
  logic              first_wait;
  logic [ITER_W-1:0] iter;
  logic [ITER_W-1:0] iter_lim;
  logic [ITER_W-1:0] iter_next;

  // iter stays below iter_lim while iterating, so this never wraps
  assign iter_next = iter + 1'b1;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // alu_start is set on the transition into START so it is high exactly
  // for the START cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      first_wait  <= 1'b0;
      alu_start   <= 1'b0;
      out_iter    <= '0;
      out_escaped <= 1'b0;
      alu_cr      <= '0;
      alu_ci      <= '0;
      alu_zr      <= '0;
      alu_zi      <= '0;
      iter        <= '0;
      iter_lim    <= '0;
    end else begin
      case (state)
        IDLE: begin
          alu_start <= 1'b0;
          if (in_valid) begin
            alu_cr   <= in_cr;
            alu_ci   <= in_ci;
            iter_lim <= max_iter;
            alu_zr   <= '0;
            alu_zi   <= '0;
            iter     <= '0;
            if (max_iter == '0) begin
              out_iter    <= '0;
              out_escaped <= 1'b0;
              state       <= DONE;
            end else begin
              alu_start <= 1'b1;
              state     <= START;
            end
          end
        end
        START: begin
          alu_start  <= 1'b0;
          first_wait <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          first_wait <= 1'b0;
          // a finished still high from the previous op is ignored here
          if (!first_wait && alu_finished) begin
            if (alu_size || alu_overflow) begin
              out_iter    <= iter;
              out_escaped <= 1'b1;
              state       <= DONE;
            end else if (iter_next == iter_lim) begin
              out_iter    <= iter_lim;
              out_escaped <= 1'b0;
              state       <= DONE;
            end else begin
              alu_zr    <= alu_out_zr;
              alu_zi    <= alu_out_zi;
              iter      <= iter_next;
              alu_start <= 1'b1;
              state     <= START;
            end
          end
        end
        DONE: begin
          alu_start <= 1'b0;
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          alu_start <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// Directed bench for mandelbrot_iter_ctrl with a behavioural single-step ALU.
// The ALU model keeps alu_finished high until one cycle after the next start,
// so a stale finished is visible in the first WAIT cycle of every op.
module tb_mandelbrot_iter_ctrl;
  import mandelbrot_pkg::*;

  localparam int W       = 8;
  localparam int IW      = 8;
  localparam int ALU_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_cr = '0;
  logic [W-1:0]  in_ci = '0;
  logic [IW-1:0] max_iter = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_iter;
  logic          out_escaped;
  logic          alu_start;
  logic          alu_finished = 1'b1;
  logic [W-1:0]  alu_cr, alu_ci, alu_zr, alu_zi;
  logic [W-1:0]  alu_out_zr = '0;
  logic [W-1:0]  alu_out_zi = '0;
  logic          alu_size = 1'b0;
  logic          alu_overflow = 1'b0;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int zr_peak = 0;
  int lat_cnt = 0;
  logic clr_pending = 1'b0;

  always #5 clk = ~clk;

  mandelbrot_iter_ctrl #(.WIDTH(W), .ITER_W(IW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cr(in_cr), .in_ci(in_ci), .max_iter(max_iter),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_iter(out_iter), .out_escaped(out_escaped),
    .alu_start(alu_start), .alu_finished(alu_finished),
    .alu_cr(alu_cr), .alu_ci(alu_ci), .alu_zr(alu_zr), .alu_zi(alu_zi),
    .alu_out_zr(alu_out_zr), .alu_out_zi(alu_out_zi),
    .alu_size(alu_size), .alu_overflow(alu_overflow)
  );

  // returns {size, overflow, next_zr, next_zi}
  function automatic logic [17:0] alu_eval(input logic [7:0] zr_b, input logic [7:0] zi_b,
                                           input logic [7:0] cr_b, input logic [7:0] ci_b);
    int zr, zi, cr, ci, nr, ni;
    logic sz, ov;
    zr = int'($signed(zr_b));
    zi = int'($signed(zi_b));
    cr = int'($signed(cr_b));
    ci = int'($signed(ci_b));
    sz = (zr * zr + zi * zi) > (4 << (2 * FRAC));
    nr = ((zr * zr - zi * zi) >>> FRAC) + cr;
    ni = ((2 * zr * zi) >>> FRAC) + ci;
    ov = (nr > 127) || (nr < -128) || (ni > 127) || (ni < -128);
    return {sz, ov, nr[7:0], ni[7:0]};
  endfunction

  always @(posedge clk) begin
    if (alu_start === 1'b1) begin
      start_cnt   <= start_cnt + 1;
      lat_cnt     <= ALU_LAT;
      clr_pending <= 1'b1;
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (clr_pending) begin
        alu_finished <= 1'b0;
        clr_pending  <= 1'b0;
      end
      if (lat_cnt == 1) begin
        alu_finished <= 1'b1;
        {alu_size, alu_overflow, alu_out_zr, alu_out_zi} <= alu_eval(alu_zr, alu_zi, alu_cr, alu_ci);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_pixel(input logic [7:0] cr, input logic [7:0] ci, input logic [7:0] mi);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    in_cr    = cr;
    in_ci    = ci;
    max_iter = mi;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    zr_peak = int'($signed(alu_zr));
    while (out_valid !== 1'b1 && n < 5000) begin
      @(negedge clk);
      if (int'($signed(alu_zr)) > zr_peak) zr_peak = int'($signed(alu_zr));
      n++;
    end
    check("done_timeout", out_valid, 1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_pixel(input string tag, input logic [7:0] cr, input logic [7:0] ci,
                           input logic [7:0] mi, input int exp_iter, input logic exp_esc,
                           input int exp_starts);
    int base;
    base = start_cnt;
    send_pixel(cr, ci, mi);
    wait_done();
    check({tag, "_iter"}, out_iter, exp_iter);
    check({tag, "_esc"}, out_escaped, exp_esc);
    check({tag, "_starts"}, start_cnt - base, exp_starts);
    release_result();
  endtask

  initial begin
    int base;
    int n;
    logic stable;

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_out_iter", out_iter, 0);
    check("rst_out_esc", out_escaped, 0);
    check("rst_z_c", {alu_zr, alu_zi, alu_cr, alu_ci}, 0);

    // c = 0 never escapes
    run_pixel("c0", 8'h00, 8'h00, 8'd16, 16, 1'b0, 16);
    // c = 1.5: z1 = 1.5 fine, z2 = 3.75 overflows
    run_pixel("c1p5", 8'h60, 8'h00, 8'd16, 1, 1'b1, 2);
    // c = 0.25 converges towards 0.5
    run_pixel("c0p25", 8'h10, 8'h00, 8'd10, 10, 1'b0, 10);
    check("c0p25_zr_peak", zr_peak <= 32, 1);
    // c = 1.5+1.5i: |z1|^2 = 4.5 escapes on the second step
    run_pixel("c1p5i", 8'h60, 8'h60, 8'd16, 1, 1'b1, 2);
    // c = i cycles between (-1,1) and (0,-1), bounded
    run_pixel("ci", 8'h00, 8'h40, 8'd7, 7, 1'b0, 7);
    // largest legal limit
    run_pixel("cmax", 8'h00, 8'h00, 8'd255, 255, 1'b0, 255);

    // backpressure then back-to-back max_iter=0 pixel
    base = start_cnt;
    send_pixel(8'h60, 8'h00, 8'd16);
    wait_done();
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_iter !== 8'd1 || out_escaped !== 1'b1 || in_ready !== 1'b0)
        stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    check("bp_iter", out_iter, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_valid", out_valid, 0);
    base = start_cnt;
    in_valid = 1'b1;
    in_cr    = 8'h33;
    in_ci    = 8'h44;
    max_iter = 8'd0;
    @(negedge clk);
    in_valid = 1'b0;
    check("zero_valid", out_valid, 1);
    check("zero_iter", out_iter, 0);
    check("zero_esc", out_escaped, 0);
    check("zero_starts", start_cnt - base, 0);
    release_result();

    // reset during WAIT, with a simultaneous in_valid
    send_pixel(8'h10, 8'h00, 8'd16);
    n = 0;
    while (alu_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_start_seen", alu_start, 1);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_cr    = 8'h60;
    max_iter = 8'd0;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_regs", {alu_start, out_iter, out_escaped, alu_cr, alu_zr}, 0);
    base = start_cnt;
    repeat (4) @(negedge clk);
    check("mid_rst_idle", {in_ready, out_valid}, 2'b10);
    check("mid_rst_nostart", start_cnt - base, 0);
    run_pixel("post_rst", 8'h60, 8'h00, 8'd16, 1, 1'b1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got 1 expected 0");
    $fatal(1);
  end

endmodule

// File: doc/mandelbrot_iter_ctrl.md
Name: mandelbrot_iter_ctrl

Overview:
- Per-pixel iteration controller feeding the Mandelbrot single-step ALU.
- Accepts one point c = (cr, ci) per handshake and starts z at 0.
- Drives the ALU one iteration at a time and feeds z back until the point escapes or max_iter is reached.
- Emits the iteration count on a valid/ready result port; the ALU is a separate instance wired to the alu_* ports.

Parameters:
- WIDTH, 8, fixed-point word width of c and z (format 2.(WIDTH-2)); must match the ALU.
- ITER_W, 8, width of the iteration counter, max_iter and out_iter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  pixel request valid
- in_ready  out  1  controller can accept a pixel (IDLE only)
- in_cr  in  WIDTH  signed real part of c
- in_ci  in  WIDTH  signed imaginary part of c
- max_iter  in  ITER_W  iteration limit, sampled on accept
- out_valid  out  1  result valid
- out_ready  in  1  result consumer ready
- out_iter  out  ITER_W  iterations completed before escape (or max_iter)
- out_escaped  out  1  1 = escaped, 0 = limit reached
- alu_start  out  1  one-cycle ALU start pulse
- alu_finished  in  1  ALU result valid
- alu_cr, alu_ci  out  WIDTH  latched c to the ALU
- alu_zr, alu_zi  out  WIDTH  current z to the ALU
- alu_out_zr, alu_out_zi  in  WIDTH  next z from the ALU
- alu_size  in  1  |z|^2 > 4 for the current z
- alu_overflow  in  1  next z not representable

Behaviour:
- FSM states: IDLE, START, WAIT, DONE. All state and outputs are registered except in_ready and out_valid, which decode state.
- Reset (any state, including mid-iteration):
  - state goes to IDLE; any in-flight pixel is dropped.
  - alu_start=0, out_iter=0, out_escaped=0, z=0, c=0, iter=0.
- IDLE:
  - in_ready=1.
  - On in_valid: latch cr, ci and max_iter; set zr=zi=0, iter=0.
  - If max_iter==0: out_iter=0, out_escaped=0, go to DONE with no ALU start.
  - Otherwise go to START.
- START: alu_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - alu_finished is ignored in the first WAIT cycle, which masks a stale finished from the previous op; it is sampled from the second cycle on.
  - On a sampled alu_finished:
    - If alu_size | alu_overflow: out_iter=iter, out_escaped=1, go to DONE.
    - Else if iter+1 == max_iter: out_iter=max_iter, out_escaped=0, go to DONE.
    - Else: zr<=alu_out_zr, zi<=alu_out_zi, iter<=iter+1, go to START.
- DONE:
  - out_valid=1; out_iter and out_escaped are held stable while out_ready=0.
  - On out_ready: go to IDLE. The next pixel can be accepted no earlier than the cycle after.
- Outside IDLE: in_ready=0 and input changes are ignored.
- alu_cr/alu_ci/alu_zr/alu_zi are driven from registers; they are stable from START through the end of WAIT.
- Escape semantics: escape is tested on the z presented to the ALU; overflow of the computed next z also counts as escape.
- Arithmetic:
  - iter counts from 0 and never exceeds max_iter; no wrap is possible.
  - max_iter = 2^ITER_W-1 is legal.
- Per-iteration latency is 1 (START) + L_alu + 1 cycles, where L_alu is the ALU start-to-finished latency.
- Simultaneous in_valid with rst: rst wins, and the pixel is not accepted.

Decomposition:
- Shared package mandelbrot_pkg holds:
  - state encoding constants IDLE/START/WAIT/DONE;
  - fixed-point helper constants: FRAC = WIDTH-2, ONE = 1<<FRAC.
- No sub-module: the ALU is instantiated by the parent alongside this block.
- The bench instantiates this block plus the real ALU (WIDTH=8) or a behavioural ALU model with configurable latency.

Test Plan:
- cr=0x00, ci=0x00, max_iter=16 → out_iter=16, out_escaped=0; exactly 16 alu_start pulses.
- cr=0x60 (1.5), ci=0 → iteration 1 (z=1.5) overflows → out_iter=1, out_escaped=1; 2 alu_start pulses.
- cr=0x10 (0.25), ci=0, max_iter=10 → converges, out_iter=10, out_escaped=0; alu_zr never exceeds 0x20.
- max_iter=0 with any c → out_valid within 2 cycles of accept, out_iter=0, out_escaped=0, alu_start never asserted.
- Result backpressure: hold out_ready=0 for 5 cycles → out_valid, out_iter and out_escaped stable, in_ready=0; release out_ready → IDLE next cycle, and a back-to-back second pixel is accepted.
- Assert rst for 1 cycle during WAIT → next cycle IDLE, in_ready=1, outputs 0, a stale alu_finished is ignored; a new pixel (cr=0x60) completes with out_iter=1.
